keyed_mux_regfile: RTL and testbench
====================================

KEYED_MUX_REGFILE -- requirements
Module: keyed_mux_regfile

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register-file address width; the file holds 2^ADDR_WIDTH entries.
REQ-002 Parameter DATA_WIDTH, default 32, width of register-file data and of mux data.
REQ-003 Parameter PC_RESET, default 32'h8000_0000, reset value of the state register.
REQ-004 Parameter NR_KEY, default 8, number of key/data pairs in the keyed mux.
REQ-005 Parameter KEY_LEN, default 7, mux key width.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 rf_wen  in  1  register-file write enable.
REQ-009 rf_waddr  in  ADDR_WIDTH  write address.
REQ-010 rf_wdata  in  DATA_WIDTH  write data.
REQ-011 rf_rs1addr, rf_rs2addr  in  ADDR_WIDTH each  read addresses.
REQ-012 rf_rs1data, rf_rs2data  out  DATA_WIDTH each  read data.
REQ-013 pc_wen  in  1  state-register load enable.
REQ-014 pc_din  in  32  state-register next value.
REQ-015 pc_dout  out  32  state-register current value.
REQ-016 mux_key  in  KEY_LEN  selection key.
REQ-017 mux_default  in  DATA_WIDTH  output when no key matches.
REQ-018 mux_lut  in  NR_KEY*(KEY_LEN+DATA_WIDTH)  packed key/data pair table.
REQ-019 mux_out  out  DATA_WIDTH  selected data.

Function
REQ-020 Register-file reads SHALL be combinational: rf_rsNdata = entry[rf_rsNaddr] in the same cycle.
REQ-021 Entry 0 SHALL always read 0; writes to address 0 SHALL be ignored.
REQ-022 On a rising edge with rf_wen=1, rst=0, and rf_waddr!=0, entry[rf_waddr] SHALL take rf_wdata.
REQ-023 There is no write-to-read bypass: a read of the address being written returns the old value until after the edge.
REQ-024 The two read ports SHALL be independent, and both may address the same entry.
REQ-025 The state register SHALL load pc_din on a rising edge when pc_wen=1 and rst=0, and hold its value otherwise.
REQ-026 The keyed mux SHALL be purely combinational, with zero latency.
REQ-027 Pair j (j=0..NR_KEY-1) SHALL occupy mux_lut[j*(KEY_LEN+DATA_WIDTH) +: KEY_LEN+DATA_WIDTH], with the key in the upper KEY_LEN bits and the data in the lower DATA_WIDTH bits.
REQ-028 mux_out SHALL equal the data of the matching pair; if no pair matches, mux_out SHALL equal mux_default.
REQ-029 If several pairs match, mux_out SHALL be the bitwise OR of all matching data fields.
REQ-030 The design SHALL contain no latches, and all outputs SHALL be X-free once reset has been applied.

Reset
REQ-031 When rst=1 at a rising edge, pc_dout SHALL become PC_RESET and all register-file entries SHALL become 0, regardless of the enables.
REQ-032 rst SHALL take priority over rf_wen and pc_wen in the same cycle; reset asserted mid-operation discards that cycle's writes.
REQ-033 The mux output SHALL be unaffected by rst.

Verification
REQ-034 Assert rst for 1 cycle with pc_wen=1 and pc_din=0x1234 -> pc_dout=0x8000_0000 and rf_rs1data=rf_rs2data=0 for any address.
REQ-035 Set rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, then read rs1addr=5 in the same cycle -> old value 0; after the edge -> 0xDEADBEEF on both ports when rs2addr=5.
REQ-036 Write 0xFFFFFFFF to address 0 -> rf_rs1data at address 0 stays 0.
REQ-037 Drive pc_wen=0 with pc_din=0x8000_0004 -> pc_dout holds; pc_wen=1 -> pc_dout=0x8000_0004 on the next edge.
REQ-038 With keys {0x03,0x23} mapped to data {0x11,0x22} and mux_default=0x99: key 0x23 -> 0x22; key 0x33 -> 0x99; duplicate key 0x03 mapped to 0x11 and 0x44 -> 0x55.
REQ-039 Apply rst while rf_wen=1, waddr=7, wdata=0xA5 -> entry 7 reads 0 after the edge.

Source files
------------

// File: rtl/keyed_mux_regfile.sv
// Register file with hard-wired zero entry, a 32-bit state register and a
// combinational keyed multiplexer; storage resets synchronously, the mux does not.
module keyed_mux_regfile #(
    parameter int          ADDR_WIDTH = 5,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] PC_RESET   = 32'h8000_0000,
    parameter int          NR_KEY     = 8,
    parameter int          KEY_LEN    = 7
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 rf_wen,
    input  logic [ADDR_WIDTH-1:0]                rf_waddr,
    input  logic [DATA_WIDTH-1:0]                rf_wdata,
    input  logic [ADDR_WIDTH-1:0]                rf_rs1addr,
    input  logic [ADDR_WIDTH-1:0]                rf_rs2addr,
    output logic [DATA_WIDTH-1:0]                rf_rs1data,
    output logic [DATA_WIDTH-1:0]                rf_rs2data,
    input  logic                                 pc_wen,
    input  logic [31:0]                          pc_din,
    output logic [31:0]                          pc_dout,
    input  logic [KEY_LEN-1:0]                   mux_key,
    input  logic [DATA_WIDTH-1:0]                mux_default,
    input  logic [NR_KEY*(KEY_LEN+DATA_WIDTH)-1:0] mux_lut,
    output logic [DATA_WIDTH-1:0]                mux_out
);

    localparam int NR_REG = 1 << ADDR_WIDTH;
    localparam int PAIR_W = KEY_LEN + DATA_WIDTH;

    logic [DATA_WIDTH-1:0] rf_d [NR_REG];
    logic [DATA_WIDTH-1:0] rf_q [NR_REG];
    logic [31:0]           pc_d;
    logic [31:0]           pc_q;
    logic                  mux_hit;
    logic [DATA_WIDTH-1:0] mux_or;

    // Reset wins over any write; entry 0 is forced to zero last so it never holds data.
    always_comb begin
        for (int i = 0; i < NR_REG; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (rf_wen) begin
            rf_d[rf_waddr] = rf_wdata;
        end
        if (rst) begin
            for (int i = 0; i < NR_REG; i++) begin
                rf_d[i] = '0;
            end
        end
        rf_d[0] = '0;
    end

    always_comb begin
        pc_d = pc_q;
        if (rst) begin
            pc_d = PC_RESET;
        end else if (pc_wen) begin
            pc_d = pc_din;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NR_REG; i++) begin
            rf_q[i] <= rf_d[i];
        end
        pc_q <= pc_d;
    end

    // Reads see the pre-edge contents: no write bypass.
    assign rf_rs1data = rf_q[rf_rs1addr];
    assign rf_rs2data = rf_q[rf_rs2addr];
    assign pc_dout    = pc_q;

    // Multiple matching pairs merge by OR rather than by priority.
    always_comb begin
        mux_hit = 1'b0;
        mux_or  = '0;
        for (int j = 0; j < NR_KEY; j++) begin
            if (mux_lut[j*PAIR_W+DATA_WIDTH +: KEY_LEN] == mux_key) begin
                mux_hit = 1'b1;
                mux_or  = mux_or | mux_lut[j*PAIR_W +: DATA_WIDTH];
            end
        end
        mux_out = mux_hit ? mux_or : mux_default;
    end

endmodule

// File: tb/tb_keyed_mux_regfile.sv
// Randomised plus directed bench for keyed_mux_regfile: expected outputs come
// from an array/queue reference model and are checked by a separate monitor.
module tb_keyed_mux_regfile;

    localparam int AW     = 5;
    localparam int DW     = 32;
    localparam int NK     = 8;
    localparam int KL     = 7;
    localparam int PAIR_W = KL + DW;
    localparam logic [31:0] PC_RST = 32'h8000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              rf_wen;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic [AW-1:0]     rf_rs1addr;
    logic [AW-1:0]     rf_rs2addr;
    logic [DW-1:0]     rf_rs1data;
    logic [DW-1:0]     rf_rs2data;
    logic              pc_wen;
    logic [31:0]       pc_din;
    logic [31:0]       pc_dout;
    logic [KL-1:0]     mux_key;
    logic [DW-1:0]     mux_default;
    logic [NK*PAIR_W-1:0] mux_lut;
    logic [DW-1:0]     mux_out;

    keyed_mux_regfile #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PC_RESET(PC_RST), .NR_KEY(NK), .KEY_LEN(KL)
    ) dut (
        .clk(clk), .rst(rst),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_rs1addr(rf_rs1addr), .rf_rs2addr(rf_rs2addr),
        .rf_rs1data(rf_rs1data), .rf_rs2data(rf_rs2data),
        .pc_wen(pc_wen), .pc_din(pc_din), .pc_dout(pc_dout),
        .mux_key(mux_key), .mux_default(mux_default), .mux_lut(mux_lut),
        .mux_out(mux_out)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [DW-1:0] model_rf [1<<AW];
    logic [31:0]   model_pc;
    logic [KL-1:0] lut_key  [NK];
    logic [DW-1:0] lut_data [NK];

    logic [4*32-1:0] exp_q[$];
    event            obs_ev;
    int              n_checks = 0;
    int              n_errors = 0;

    function automatic logic [DW-1:0] ref_mux(input logic [KL-1:0] key);
        logic [DW-1:0] hits[$];
        logic [DW-1:0] r;
        for (int j = 0; j < NK; j++) begin
            if (lut_key[j] == key) hits.push_back(lut_data[j]);
        end
        if (hits.size() == 0) return mux_default;
        r = '0;
        foreach (hits[k]) r = r | hits[k];
        return r;
    endfunction

    task automatic pack_lut();
        for (int j = 0; j < NK; j++) begin
            mux_lut[j*PAIR_W +: PAIR_W] = {lut_key[j], lut_data[j]};
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: pops one expectation per observation strobe
    initial begin
        logic [4*32-1:0] e;
        forever begin
            @(obs_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rs1data", rf_rs1data, e[127:96]);
                check("rs2data", rf_rs2data, e[95:64]);
                check("pc_dout", pc_dout,    e[63:32]);
                check("mux_out", mux_out,    e[31:0]);
            end
        end
    end

    // Called at a negedge with inputs already driven; advances one clock.
    task automatic step(input bit chk);
        #1;
        if (chk) begin
            exp_q.push_back({model_rf[rf_rs1addr], model_rf[rf_rs2addr], model_pc, ref_mux(mux_key)});
            -> obs_ev;
            #1;
        end
        if (rst) begin
            model_pc = PC_RST;
            foreach (model_rf[i]) model_rf[i] = '0;
        end else begin
            if (pc_wen) model_pc = pc_din;
            if (rf_wen && rf_waddr != 0) model_rf[rf_waddr] = rf_wdata;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; rf_wen = 0; pc_wen = 0;
        rf_waddr = '0; rf_wdata = '0; pc_din = '0;
    endtask

    initial begin
        rst = 1; rf_wen = 1; rf_waddr = 5'd7; rf_wdata = 32'hA5;
        rf_rs1addr = 5'd3; rf_rs2addr = 5'd9;
        pc_wen = 1; pc_din = 32'h1234;
        mux_key = 7'h00; mux_default = 32'h99;
        for (int j = 0; j < NK; j++) begin
            lut_key[j] = KL'(7'h70 + j);
            lut_data[j] = $urandom;
        end
        lut_key[0] = 7'h03; lut_data[0] = 32'h11;
        lut_key[1] = 7'h23; lut_data[1] = 32'h22;
        pack_lut();
        @(negedge clk);
        step(0);

        // reset results with enables held high during reset
        idle_inputs();
        rf_rs1addr = 5'd7; rf_rs2addr = 5'd31;
        step(1);

        // no bypass, then both ports read the new value
        rf_wen = 1; rf_waddr = 5'd5; rf_wdata = 32'hDEADBEEF;
        rf_rs1addr = 5'd5; rf_rs2addr = 5'd5;
        step(1);
        rf_wen = 0;
        step(1);

        // entry 0 ignores writes
        rf_wen = 1; rf_waddr = 5'd0; rf_wdata = 32'hFFFF_FFFF;
        rf_rs1addr = 5'd0; rf_rs2addr = 5'd0;
        step(1);
        rf_wen = 0;
        step(1);

        // state register hold and load
        pc_wen = 0; pc_din = 32'h8000_0004;
        step(1);
        step(1);
        pc_wen = 1;
        step(1);
        pc_wen = 0;
        step(1);

        // keyed mux: hit, miss, duplicate key OR
        mux_key = 7'h23; step(1);
        mux_key = 7'h33; step(1);
        lut_key[2] = 7'h03; lut_data[2] = 32'h44; pack_lut();
        mux_key = 7'h03; step(1);

        // reset discards a concurrent write to entry 7
        rf_wen = 1; rf_waddr = 5'd7; rf_wdata = 32'h1;
        step(0);
        rst = 1; rf_waddr = 5'd7; rf_wdata = 32'hA5;
        step(0);
        idle_inputs();
        rf_rs1addr = 5'd7; rf_rs2addr = 5'd7;
        step(1);

        // randomised traffic
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 49) == 0);
            rf_wen     = $urandom_range(0, 1);
            rf_waddr   = $urandom_range(0, 7);
            rf_wdata   = $urandom;
            rf_rs1addr = $urandom_range(0, 7);
            rf_rs2addr = $urandom_range(0, 7);
            pc_wen     = $urandom_range(0, 1);
            pc_din     = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                for (int j = 0; j < NK; j++) begin
                    lut_key[j]  = $urandom_range(0, 7);
                    lut_data[j] = $urandom;
                end
                mux_default = $urandom;
                pack_lut();
            end
            mux_key = $urandom_range(0, 9);
            step(1);
        end

        #20;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
